// File: rtl/draw_rect_multi_pkg.sv
// Shared types for the multi-rectangle overlay: rectangle config record, pixel
// stream record, commit FSM states and the 50 % channel blend helper.
package draw_rect_multi_pkg;

    localparam int RGB_W       = 12;
    localparam int VGA_CNT_W   = 11;
    // Stored coordinate width; the top-level COORD_W must not exceed it.
    localparam int CFG_COORD_W = 16;

    typedef struct packed {
        logic [CFG_COORD_W-1:0] xpos;
        logic [CFG_COORD_W-1:0] ypos;
        logic [CFG_COORD_W-1:0] w;
        logic [CFG_COORD_W-1:0] h;
        logic [RGB_W-1:0]       rgb;
        logic                   en;
        logic                   blend;
    } rect_cfg_t;

    typedef struct packed {
        logic [VGA_CNT_W-1:0] hcount;
        logic [VGA_CNT_W-1:0] vcount;
        logic                 hsync;
        logic                 vsync;
        logic                 hblnk;
        logic                 vblnk;
        logic [RGB_W-1:0]     rgb;
    } vga_sig_t;

    typedef enum logic {
        CMT_IDLE    = 1'b0,
        CMT_PENDING = 1'b1
    } commit_state_e;

    function automatic logic [RGB_W-1:0] blend_rgb(input logic [RGB_W-1:0] fg,
                                                   input logic [RGB_W-1:0] bg);
        logic [4:0]       sum;
        logic [RGB_W-1:0] res;
        res = '0;
        for (int c = 0; c < 3; c++) begin
            sum = {1'b0, fg[c*4 +: 4]} + {1'b0, bg[c*4 +: 4]};
            res[c*4 +: 4] = sum[4:1];
        end
        return res;
    endfunction

endpackage

// File: rtl/vga_bus.sv
// VGA timing/colour stream passed between drawing stages.
interface vga_bus;
    logic [draw_rect_multi_pkg::VGA_CNT_W-1:0] hcount;
    logic [draw_rect_multi_pkg::VGA_CNT_W-1:0] vcount;
    logic                                      hsync;
    logic                                      vsync;
    logic                                      hblnk;
    logic                                      vblnk;
    logic [draw_rect_multi_pkg::RGB_W-1:0]     rgb;

    modport IN  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport OUT (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/draw_rect_multi_rect_hit.sv
// Combinational point-in-rectangle test; sums carry one extra bit so a
// rectangle running past the coordinate range never wraps to low counts.
module rect_hit
    import draw_rect_multi_pkg::*;
(
    input  rect_cfg_t            cfg_i,
    input  logic [VGA_CNT_W-1:0] hcount_i,
    input  logic [VGA_CNT_W-1:0] vcount_i,
    output logic                 hit_o
);

    logic [CFG_COORD_W:0] x0, x1, y0, y1, hc, vc;
    logic                 unused_cfg;

    assign x0 = {1'b0, cfg_i.xpos};
    assign y0 = {1'b0, cfg_i.ypos};
    assign x1 = x0 + {1'b0, cfg_i.w};
    assign y1 = y0 + {1'b0, cfg_i.h};
    assign hc = {{(CFG_COORD_W + 1 - VGA_CNT_W){1'b0}}, hcount_i};
    assign vc = {{(CFG_COORD_W + 1 - VGA_CNT_W){1'b0}}, vcount_i};

    assign hit_o = cfg_i.en && (|cfg_i.w) && (|cfg_i.h)
                && (hc >= x0) && (hc < x1)
                && (vc >= y0) && (vc < y1);

    assign unused_cfg = ^{cfg_i.rgb, cfg_i.blend};

endmodule

// File: rtl/draw_rect_multi.sv
// Overlays N_RECT rectangles on a vga_bus stream with a 2-cycle pipeline; scene
// updates commit at vblank start. Optional 50 % blending: DRAW_RECT_BLEND_EN.
module draw_rect_multi
    import draw_rect_multi_pkg::*;
#(
    parameter  int N_RECT  = 4,
    parameter  int COORD_W = 11,
    localparam int IDX_W   = (N_RECT > 1) ? $clog2(N_RECT) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    vga_bus.IN                 bus_in,
    vga_bus.OUT                bus_out,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [IDX_W-1:0]   cfg_idx,
    input  logic [COORD_W-1:0] cfg_xpos,
    input  logic [COORD_W-1:0] cfg_ypos,
    input  logic [COORD_W-1:0] cfg_w,
    input  logic [COORD_W-1:0] cfg_h,
    input  logic [RGB_W-1:0]   cfg_rgb,
    input  logic               cfg_en,
    input  logic               cfg_blend,
    input  logic               commit,
    output logic               commit_pending
);

    rect_cfg_t        shadow_q [N_RECT];
    rect_cfg_t        active_q [N_RECT];
    rect_cfg_t        wr_cfg;
    commit_state_e    state_q, state_d;
    logic             vblnk_prev_q, apply_edge, wr_en;
    logic [N_RECT-1:0] hit, hit_q;
    vga_sig_t         bus_in_sig, s1_q, s2_d, s2_q;
    logic             win_found;
    logic [RGB_W-1:0] win_rgb;

    assign bus_in_sig     = {bus_in.hcount, bus_in.vcount, bus_in.hsync, bus_in.vsync,
                             bus_in.hblnk, bus_in.vblnk, bus_in.rgb};
    assign apply_edge     = bus_in.vblnk && !vblnk_prev_q;
    assign commit_pending = (state_q == CMT_PENDING);
    assign cfg_ready      = !commit_pending;
    assign wr_en          = cfg_valid && cfg_ready && (int'(cfg_idx) < N_RECT);

    // NOTE: every field gets a default before any conditional update, so no latch is inferred.
    always_comb begin
        wr_cfg      = '0;
        wr_cfg.xpos = CFG_COORD_W'(cfg_xpos);
        wr_cfg.ypos = CFG_COORD_W'(cfg_ypos);
        wr_cfg.w    = CFG_COORD_W'(cfg_w);
        wr_cfg.h    = CFG_COORD_W'(cfg_h);
        wr_cfg.rgb  = cfg_rgb;
        wr_cfg.en   = cfg_en;
`ifdef DRAW_RECT_BLEND_EN
        wr_cfg.blend = cfg_blend;
`endif
    end

`ifndef DRAW_RECT_BLEND_EN
    logic unused_blend;
    assign unused_blend = cfg_blend;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= CMT_IDLE;
        else        state_q <= state_d;
    end

    // A commit arriving on the vblank edge itself only arms; it applies next frame.
    always_comb begin
        state_d = state_q;
        case (state_q)
            CMT_IDLE:    if (commit)     state_d = CMT_PENDING;
            CMT_PENDING: if (apply_edge) state_d = CMT_IDLE;
            default:                     state_d = CMT_IDLE;
        endcase
    end

    // NOTE: both banks are reset explicitly so a mid-frame reset leaves every rectangle disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_RECT; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
            vblnk_prev_q <= 1'b0;
        end else begin
            vblnk_prev_q <= bus_in.vblnk;
            if (wr_en)                        shadow_q[cfg_idx] <= wr_cfg;
            if (commit_pending && apply_edge) active_q <= shadow_q;
        end
    end

    for (genvar g = 0; g < N_RECT; g++) begin : g_hit
        rect_hit u_hit (
            .cfg_i    (active_q[g]),
            .hcount_i (bus_in.hcount),
            .vcount_i (bus_in.vcount),
            .hit_o    (hit[g])
        );
    end

    always_comb begin
        win_found = 1'b0;
        win_rgb   = '0;
        s2_d      = s1_q;
        // Scan downwards so the lowest-index hit is the one left standing.
        for (int i = N_RECT - 1; i >= 0; i--) begin
            if (hit_q[i]) begin
                win_found = 1'b1;
`ifdef DRAW_RECT_BLEND_EN
                win_rgb   = active_q[i].blend ? blend_rgb(active_q[i].rgb, s1_q.rgb)
                                              : active_q[i].rgb;
`else
                win_rgb   = active_q[i].rgb;
`endif
            end
        end
        if (win_found && !s1_q.hblnk && !s1_q.vblnk) s2_d.rgb = win_rgb;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q  <= '0;
            hit_q <= '0;
            s2_q  <= '0;
        end else begin
            s1_q  <= bus_in_sig;
            hit_q <= hit;
            s2_q  <= s2_d;
        end
    end

    assign bus_out.hcount = s2_q.hcount;
    assign bus_out.vcount = s2_q.vcount;
    assign bus_out.hsync  = s2_q.hsync;
    assign bus_out.vsync  = s2_q.vsync;
    assign bus_out.hblnk  = s2_q.hblnk;
    assign bus_out.vblnk  = s2_q.vblnk;
    assign bus_out.rgb    = s2_q.rgb;

endmodule
